// File: rtl/tape_pkg.sv
// tape_pkg: shared state encoding, sizes and end-of-tape marker for the tape sequencer
package tape_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [7:0] END_MARK = 8'hFF;
  typedef enum logic [2:0] {IDLE, REC, PLAY_WAIT, PLAY_READ, PLAY_CAPT} state_t;
endpackage

// File: rtl/tape_sequencer.sv
// tape_sequencer: records scanned notes into an external memory and replays them on tempo ticks
module tape_sequencer
  import tape_pkg::*;
#(
  parameter int ADDR_W = tape_pkg::ADDR_W,
  parameter int DATA_W = tape_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode_rec,
  input  logic              start,
  input  logic              stop,
  input  logic [DATA_W-1:0] note_in,
  input  logic              note_valid,
  output logic              note_ready,
  input  logic              tick,
  input  logic              loop_en,
  output logic              mem_write_en,
  output logic              mem_read_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic [DATA_W-1:0] note_out,
  output logic              note_out_valid,
  output logic [ADDR_W:0]   length,
  output logic              busy,
  output logic              done,
  output logic              full
);
  localparam logic [ADDR_W:0] LAST_LEN = (ADDR_W+1)'(2 ** ADDR_W - 1);
  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr, r_rd_ptr, r_addr;
  logic [ADDR_W:0]   r_length;
  logic [DATA_W-1:0] r_din, r_note;
  logic              r_we, r_re, r_nv, r_done, r_full;
  logic              w_hs, w_last, w_end;
  assign note_ready     = r_state == REC;
  assign busy           = r_state != IDLE;
  assign w_hs           = note_valid & note_ready;
  assign w_end          = note_in == DATA_W'(END_MARK);
  assign w_last         = {1'b0, r_rd_ptr} == r_length - 1'b1;
  assign mem_write_en   = r_we;
  assign mem_read_en    = r_re;
  assign mem_addr       = r_addr;
  assign mem_data_in    = r_din;
  assign note_out       = r_note;
  assign note_out_valid = r_nv;
  assign length         = r_length;
  assign done           = r_done;
  assign full           = r_full;
  // Sequencer FSM: strobes default low each cycle, stop overrides every state
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_length <= '0;
      r_full   <= 1'b0;
      r_note   <= '0;
      r_nv     <= 1'b0;
      r_done   <= 1'b0;
      r_we     <= 1'b0;
      r_re     <= 1'b0;
      r_addr   <= '0;
      r_din    <= '0;
    end else begin
      r_we   <= 1'b0;
      r_re   <= 1'b0;
      r_nv   <= 1'b0;
      r_done <= 1'b0;
      if (stop) r_state <= IDLE;
      else case (r_state)
        IDLE:
          if (start && mode_rec) begin
            r_state  <= REC;
            r_wr_ptr <= '0;
            r_length <= '0;
            r_full   <= 1'b0;
          end else if (start && r_length != '0) begin
            r_state  <= PLAY_WAIT;
            r_rd_ptr <= '0;
          end else if (start) r_done <= 1'b1;
        REC:
          if (w_hs && w_end) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else if (w_hs) begin
            r_we     <= 1'b1;
            r_addr   <= r_wr_ptr;
            r_din    <= note_in;
            r_length <= r_length + 1'b1;
            if (r_length == LAST_LEN) begin
              r_full  <= 1'b1;
              r_state <= IDLE;
              r_done  <= 1'b1;
            end else r_wr_ptr <= r_wr_ptr + 1'b1;
          end
        PLAY_WAIT:
          if (tick) begin
            r_state <= PLAY_READ;
            r_re    <= 1'b1;
            r_addr  <= r_rd_ptr;
          end
        PLAY_READ: r_state <= PLAY_CAPT;
        PLAY_CAPT: begin
          r_note <= mem_data_out;
          r_nv   <= 1'b1;
          if (w_last && !loop_en) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end else begin
            r_state  <= PLAY_WAIT;
            r_rd_ptr <= w_last ? '0 : r_rd_ptr + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tape_sequencer.sv
// tb_tape_sequencer: scoreboard bench for tape_sequencer with a behavioural 1024x8 memory
module tb_tape_sequencer;
  logic        clk = 0, rst = 1, mode_rec = 0, start = 0, stop = 0;
  logic [7:0]  note_in = 0;
  logic        note_valid = 0, tick = 0, loop_en = 0;
  logic        note_ready, mem_write_en, mem_read_en, note_out_valid, busy, done, full;
  logic [9:0]  mem_addr;
  logic [7:0]  mem_data_in, mem_data_out, note_out;
  logic [10:0] length;
  logic [7:0]  mem [1024];
  logic [17:0] exp_wr [$];
  logic [7:0]  exp_note [$];
  int          exp_cyc [$];
  int          total = 0, bad = 0, cyc = 0, done_cnt = 0, rd_cnt = 0, wr_cnt = 0;

  tape_sequencer dut (
    .clk(clk), .rst(rst), .mode_rec(mode_rec), .start(start), .stop(stop),
    .note_in(note_in), .note_valid(note_valid), .note_ready(note_ready),
    .tick(tick), .loop_en(loop_en), .mem_write_en(mem_write_en), .mem_read_en(mem_read_en),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
    .note_out(note_out), .note_out_valid(note_out_valid), .length(length),
    .busy(busy), .done(done), .full(full)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_write_en) mem[mem_addr] <= mem_data_in;
    if (mem_read_en) mem_data_out <= mem[mem_addr];
  end

  always @(posedge clk)
    if (!rst) assert (!(mem_write_en && mem_read_en)) else $error("FAIL en_overlap we=%b re=%b", mem_write_en, mem_read_en);

  always @(negedge clk) begin : mon
    logic [17:0] e;
    if (done === 1'b1) done_cnt++;
    if (mem_read_en === 1'b1) rd_cnt++;
    if (mem_write_en === 1'b1) begin
      wr_cnt++;
      total++;
      if (exp_wr.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%0d data=%h", mem_addr, mem_data_in);
      end else begin
        e = exp_wr.pop_front();
        if ({mem_addr, mem_data_in} !== e) begin
          bad++;
          $display("FAIL write got addr=%0d data=%h want addr=%0d data=%h", mem_addr, mem_data_in, e[17:8], e[7:0]);
        end
      end
    end
    if (note_out_valid === 1'b1) begin
      total++;
      if (exp_note.size() == 0) begin
        bad++;
        $display("FAIL unexpected_note note=%h", note_out);
      end else begin
        int c;
        logic [7:0] n;
        n = exp_note.pop_front();
        c = exp_cyc.pop_front();
        if (note_out !== n || cyc != c) begin
          bad++;
          $display("FAIL note got %h at cyc %0d want %h at cyc %0d", note_out, cyc, n, c);
        end
      end
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (3) step();
    rst = 0;
    total++;
    if ({busy, done, full, note_ready, mem_write_en, mem_read_en, note_out_valid} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags got %b want 0", {busy, done, full, note_ready, mem_write_en, mem_read_en, note_out_valid});
    end
    total++;
    if (length !== 11'd0 || mem_addr !== 10'd0 || mem_data_in !== 8'd0 || note_out !== 8'd0) begin
      bad++;
      $display("FAIL reset_values len=%0d addr=%0d din=%h nout=%h want 0", length, mem_addr, mem_data_in, note_out);
    end
  endtask

  task automatic test_record;
    logic [7:0] notes [3] = '{8'h10, 8'h20, 8'h30};
    int d0 = done_cnt;
    mode_rec = 1; start = 1;
    step();
    start = 0;
    total++;
    if (note_ready !== 1'b1) begin
      bad++;
      $display("FAIL rec_ready got %b want 1", note_ready);
    end
    for (int i = 0; i < 3; i++) begin
      note_in = notes[i]; note_valid = 1;
      exp_wr.push_back({10'(i), notes[i]});
      step();
    end
    note_in = 8'hFF;
    step();
    note_valid = 0;
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || length !== 11'd3) begin
      bad++;
      $display("FAIL rec_end done=%b busy=%b len=%0d want 1 0 3", done, busy, length);
    end
    repeat (4) step();
    total++;
    if (done_cnt - d0 != 1 || exp_wr.size() != 0) begin
      bad++;
      $display("FAIL rec_done_count got %0d pending=%0d want 1 0", done_cnt - d0, exp_wr.size());
    end
  endtask

  task automatic test_play(input logic lp, input int n, input int gap);
    logic [7:0] notes [3] = '{8'h10, 8'h20, 8'h30};
    int d0 = done_cnt;
    loop_en = lp; mode_rec = 0; start = 1;
    step();
    start = 0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL play_busy got %b want 1", busy);
    end
    for (int i = 0; i < n; i++) begin
      repeat (gap) step();
      tick = 1;
      exp_note.push_back(notes[i % 3]);
      exp_cyc.push_back(cyc + 3);
      step();
      tick = 0;
    end
    repeat (5) step();
    if (lp) begin
      stop = 1;
      step();
      stop = 0;
    end
    total++;
    if (busy !== 1'b0 || done_cnt - d0 != (lp ? 0 : 1) || exp_note.size() != 0) begin
      bad++;
      $display("FAIL play_end loop=%b busy=%b dones=%0d pending=%0d want 0 %0d 0", lp, busy, done_cnt - d0, exp_note.size(), lp ? 0 : 1);
    end
  endtask

  task automatic test_stop_and_drop;
    int r0, d0 = done_cnt;
    mode_rec = 0; loop_en = 0; start = 1;
    step();
    start = 0;
    r0 = rd_cnt;
    stop = 1;
    step();
    stop = 0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL stop_wait busy=%b want 0", busy);
    end
    repeat (3) step();
    total++;
    if (rd_cnt != r0 || done_cnt != d0) begin
      bad++;
      $display("FAIL stop_quiet reads=%0d dones=%0d want 0 0", rd_cnt - r0, done_cnt - d0);
    end
    start = 1; stop = 1;
    step();
    start = 0; stop = 0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL start_stop busy=%b want 0", busy);
    end
    start = 1;
    step();
    start = 0;
    step();
    r0 = rd_cnt;
    tick = 1;
    exp_note.push_back(8'h10);
    exp_cyc.push_back(cyc + 3);
    repeat (3) step();
    tick = 0;
    repeat (5) step();
    stop = 1;
    step();
    stop = 0;
    total++;
    if (rd_cnt - r0 != 1 || exp_note.size() != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL tick_drop reads=%0d pending=%0d busy=%b want 1 0 0", rd_cnt - r0, exp_note.size(), busy);
    end
  endtask

  task automatic test_rst_rec;
    int w0;
    mode_rec = 1; start = 1;
    step();
    start = 0;
    note_in = 8'h55; note_valid = 1;
    exp_wr.push_back({10'd0, 8'h55});
    step();
    note_in = 8'h66; rst = 1;
    step();
    rst = 0; note_valid = 0;
    w0 = wr_cnt;
    total++;
    if (busy !== 1'b0 || length !== 11'd0 || mem_write_en !== 1'b0) begin
      bad++;
      $display("FAIL rst_rec busy=%b len=%0d we=%b want 0 0 0", busy, length, mem_write_en);
    end
    repeat (3) step();
    total++;
    if (wr_cnt != w0 || exp_wr.size() != 0) begin
      bad++;
      $display("FAIL rst_quiet writes=%0d pending=%0d want 0 0", wr_cnt - w0, exp_wr.size());
    end
  endtask

  task automatic test_full;
    int d0 = done_cnt;
    mode_rec = 1; start = 1;
    step();
    start = 0;
    for (int i = 0; i < 1024; i++) begin
      note_in = 8'(i % 200); note_valid = 1;
      exp_wr.push_back({10'(i), 8'(i % 200)});
      step();
    end
    note_in = 8'h07;
    total++;
    if (note_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_ready got %b want 0", note_ready);
    end
    step();
    note_valid = 0;
    total++;
    if (full !== 1'b1 || length !== 11'd1024 || busy !== 1'b0) begin
      bad++;
      $display("FAIL full_state full=%b len=%0d busy=%b want 1 1024 0", full, length, busy);
    end
    repeat (3) step();
    total++;
    if (done_cnt - d0 != 1 || exp_wr.size() != 0) begin
      bad++;
      $display("FAIL full_done dones=%0d pending=%0d want 1 0", done_cnt - d0, exp_wr.size());
    end
  endtask

  initial begin
    test_reset();
    test_record();
    test_play(1'b0, 3, 19);
    test_play(1'b1, 7, 5);
    test_stop_and_drop();
    test_rst_rec();
    test_full();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tape_sequencer.md
TAPE_SEQUENCER -- requirements
Module: tape_sequencer

Interface
REQ-001 Parameter ADDR_W, default 10, memory address width; DEPTH = 2**ADDR_W = 1024.
REQ-002 Parameter DATA_W, default 8, note byte width.
REQ-003 clk  in  1  single clock; all logic on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 mode_rec  in  1  sampled with start: 1 = record, 0 = play.
REQ-006 start  in  1  one-cycle command pulse.
REQ-007 stop  in  1  abort command; has priority over everything except rst.
REQ-008 note_in  in  DATA_W  note byte from tape scanner.
REQ-009 note_valid  in  1  note_in is valid.
REQ-010 note_ready  out  1  combinational; high iff state==REC.
REQ-011 tick  in  1  one-cycle tempo pulse.
REQ-012 loop_en  in  1  replay from address 0 after the last note.
REQ-013 mem_write_en, mem_read_en  out  1 each  registered memory enables.
REQ-014 mem_addr  out  ADDR_W  registered memory address.
REQ-015 mem_data_in  out  DATA_W  registered write data.
REQ-016 mem_data_out  in  DATA_W  memory read data; valid one edge after mem_read_en.
REQ-017 note_out  out  DATA_W  registered played note; note_out_valid  out  1  one-cycle strobe.
REQ-018 length  out  ADDR_W+1  number of stored notes; busy  out  1  state!=IDLE; done  out  1  one-cycle pulse; full  out  1  sticky.

Function
REQ-019 States: IDLE, REC, PLAY_WAIT, PLAY_READ, PLAY_CAPT.
REQ-020 mem_write_en and mem_read_en shall never be high in the same cycle.
REQ-021 IDLE: start & mode_rec -> REC; wr_ptr=0, length=0, full=0.
REQ-022 IDLE: start & !mode_rec & length!=0 -> PLAY_WAIT, rd_ptr=0; if length==0, stay IDLE and pulse done.
REQ-023 REC: a handshake (note_valid & note_ready) at edge k with note_in!=8'hFF drives mem_write_en=1, mem_addr=wr_ptr, mem_data_in=note_in during cycle k+1; wr_ptr and length increment; back-to-back handshakes write on consecutive cycles.
REQ-024 REC: note_in==8'hFF (end mark) is accepted, not written; -> IDLE with done pulse.
REQ-025 REC: the handshake that makes length==DEPTH sets full and -> IDLE with done pulse; wr_ptr shall not wrap.
REQ-026 PLAY_WAIT: tick -> PLAY_READ; mem_read_en=1, mem_addr=rd_ptr for exactly one cycle.
REQ-027 PLAY_READ -> PLAY_CAPT unconditionally; at the PLAY_CAPT edge, mem_data_out is latched into note_out and note_out_valid pulses, which is two edges after the edge that sampled tick.
REQ-028 PLAY_CAPT, rd_ptr==length-1: if loop_en, rd_ptr=0 -> PLAY_WAIT; else -> IDLE with done pulse. Otherwise rd_ptr++ -> PLAY_WAIT.
REQ-029 A tick arriving in PLAY_READ or PLAY_CAPT is dropped and not queued.
REQ-030 stop in any state -> IDLE at the next edge; no memory enable is issued in the following cycle; length keeps the count accepted so far; no done pulse.
REQ-031 start while busy is ignored; start & stop in the same cycle -> stop wins.
REQ-032 In every cycle without an operation, mem enables are 0; mem_addr and mem_data_in hold their values.

Reset
REQ-033 rst sets state=IDLE, wr_ptr=rd_ptr=0, length=0, full=0, note_out=0, note_out_valid=0, done=0, mem_write_en=mem_read_en=0, mem_addr=0, mem_data_in=0.
REQ-034 rst mid-record or mid-play aborts immediately; stored memory contents are not cleared.

Structure
REQ-035 Shared package tape_pkg holds: state enum, ADDR_W, DATA_W, DEPTH, END_MARK=8'hFF.
REQ-036 No sub-module is instantiated; the parent top instantiates tape_sequencer beside the 1024x8 memory.

Verification
REQ-037 Record 0x10,0x20,0x30 then 0xFF: writes land at addresses 0..2, length=3, done pulses once, and no write occurs for 0xFF.
REQ-038 Play with loop_en=0, ticks 20 cycles apart: note_out gives 0x10,0x20,0x30; each valid comes 2 edges after its tick; done follows the third note; busy=0 afterwards.
REQ-039 Play with loop_en=1 over 7 ticks: output is 0x10,0x20,0x30,0x10,0x20,0x30,0x10.
REQ-040 Record 1024 notes back-to-back: full=1, length=1024, state returns to IDLE, and a 1025th note_valid sees note_ready=0.
REQ-041 Assert stop during PLAY_WAIT, and separately assert rst during REC: both return to IDLE within 1 edge with no further mem enables; a tick in PLAY_READ is dropped.
REQ-042 Assertion active throughout the run: write and read enables are never high together.
